// File: rtl/sram_pkg.sv
// sram_pkg: shared defaults, FSM state encoding and the reference pattern
// function used by the sram_bist self-test initiator.
package sram_pkg;

    localparam int DEF_ADDR_W = 19;
    localparam int DEF_DATA_W = 9;
    localparam int DEF_ERR_W  = 16;

    // The second-pass states are only reachable when the inverted pass is built in.
    typedef enum logic [3:0] {
        ST_IDLE,
        ST_WR_REQ,
        ST_WR_WAIT,
        ST_RD_REQ,
        ST_RD_WAIT,
        ST_DONE,
        ST_WR2_REQ,
        ST_WR2_WAIT,
        ST_RD2_REQ,
        ST_RD2_WAIT
    } bist_state_e;

    // Address-derived test word: low address bits XOR seed, optionally inverted.
    function automatic logic [DEF_DATA_W-1:0] pattern(
        input logic [DEF_DATA_W-1:0] a,
        input logic [DEF_DATA_W-1:0] seed,
        input logic                  invert
    );
        logic [DEF_DATA_W-1:0] p;
        p = a ^ seed;
        return invert ? ~p : p;
    endfunction

endpackage

// File: rtl/sram_bist_pattern.sv
// sram_bist_pattern: combinational test-word generator. Takes only the low
// DATA_W address bits, because the pattern never looks above them.
module sram_bist_pattern
    import sram_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W
) (
    input  logic [DATA_W-1:0] addr_i,
    input  logic [DATA_W-1:0] seed_i,
    input  logic              invert_i,
    output logic [DATA_W-1:0] pattern_o
);

    // The default width reuses the package function; other widths use the same expression.
    generate
        if (DATA_W == DEF_DATA_W) begin : g_pkg
            assign pattern_o = pattern(addr_i, seed_i, invert_i);
        end else begin : g_generic
            assign pattern_o = invert_i ? ~(addr_i ^ seed_i) : (addr_i ^ seed_i);
        end
    endgenerate

endmodule

// File: rtl/sram_bist.sv
// sram_bist: built-in self-test initiator for the SRAM controller's system port.
// Writes pattern(a) over [addr_first..addr_last], reads it back and counts mismatches.
// Optional feature: define SRAM_BIST_INV_PASS_EN to add a second write+read pass
// using the inverted pattern; errors from both passes accumulate.
module sram_bist
    import sram_pkg::*;
#(
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int DATA_W = DEF_DATA_W,
    parameter int ERR_W  = DEF_ERR_W
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              start,
    input  logic [ADDR_W-1:0] addr_first,
    input  logic [ADDR_W-1:0] addr_last,
    input  logic [DATA_W-1:0] seed,
    output logic              mem,
    output logic              rw,
    output logic [ADDR_W-1:0] addr,
    output logic [DATA_W-1:0] data_f2s,
    input  logic              ready,
    input  logic [DATA_W-1:0] data_s2f_r,
    output logic              busy,
    output logic              done,
    output logic              pass,
    output logic [ERR_W-1:0]  err_cnt,
    output logic [ADDR_W-1:0] first_err_addr
);

    bist_state_e       state_q;
    logic [ADDR_W-1:0] cur_q;
    logic [ADDR_W-1:0] first_q;
    logic [ADDR_W-1:0] last_q;
    logic [DATA_W-1:0] seed_q;
    logic              waited_q;
    logic              mem_q;
    logic              rw_q;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] data_q;
    logic              busy_q;
    logic              done_q;
    logic              pass_q;
    logic [ERR_W-1:0]  err_q;
    logic [ADDR_W-1:0] firstErr_q;

    logic              lastHit;
    logic [ADDR_W-1:0] cur_d;
    logic              inIdle;
    logic [DATA_W-1:0] genAddr;
    logic [DATA_W-1:0] genSeed;
    logic              genInv;
    logic              chkInv;
    logic [DATA_W-1:0] genPattern;
    logic [DATA_W-1:0] chkPattern;
    logic              mismatch;
    logic [ERR_W-1:0]  err_d;

    // Next address (wrapping back to the range start, never past addr_last) and pattern selects.
    always_comb begin
        lastHit = (cur_q == last_q);
        cur_d   = lastHit ? first_q : cur_q + ADDR_W'(1);
        inIdle  = (state_q == ST_IDLE) || (state_q == ST_DONE);
        genAddr = inIdle ? addr_first[DATA_W-1:0] : cur_d[DATA_W-1:0];
        genSeed = inIdle ? seed : seed_q;
        genInv  = 1'b0;
        chkInv  = 1'b0;
`ifdef SRAM_BIST_INV_PASS_EN
        genInv  = (state_q == ST_RD_WAIT) || (state_q == ST_WR2_WAIT);
        chkInv  = (state_q == ST_RD2_WAIT);
`endif
    end

    sram_bist_pattern #(.DATA_W(DATA_W)) u_genPattern (
        .addr_i    (genAddr),
        .seed_i    (genSeed),
        .invert_i  (genInv),
        .pattern_o (genPattern)
    );

    sram_bist_pattern #(.DATA_W(DATA_W)) u_chkPattern (
        .addr_i    (cur_q[DATA_W-1:0]),
        .seed_i    (seed_q),
        .invert_i  (chkInv),
        .pattern_o (chkPattern)
    );

    assign mismatch = (data_s2f_r != chkPattern);
    assign err_d    = (mismatch && !(&err_q)) ? err_q + ERR_W'(1) : err_q;

    // Test sequencer: every request output is registered and set on entry to a REQ state.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= ST_IDLE;
            cur_q      <= '0;
            first_q    <= '0;
            last_q     <= '0;
            seed_q     <= '0;
            waited_q   <= 1'b0;
            mem_q      <= 1'b0;
            rw_q       <= 1'b1;
            addr_q     <= '0;
            data_q     <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            pass_q     <= 1'b0;
            err_q      <= '0;
            firstErr_q <= '0;
        end else begin
            case (state_q)
                ST_IDLE, ST_DONE: begin
                    if (start) begin
                        first_q    <= addr_first;
                        last_q     <= addr_last;
                        seed_q     <= seed;
                        err_q      <= '0;
                        firstErr_q <= '0;
                        done_q     <= 1'b0;
                        pass_q     <= 1'b0;
                        if (addr_first > addr_last) begin
                            state_q <= ST_DONE;
                            done_q  <= 1'b1;
                            pass_q  <= 1'b1;
                        end else begin
                            cur_q   <= addr_first;
                            busy_q  <= 1'b1;
                            state_q <= ST_WR_REQ;
                            mem_q   <= 1'b1;
                            rw_q    <= 1'b0;
                            addr_q  <= addr_first;
                            data_q  <= genPattern;
                        end
                    end
                end
                ST_WR_REQ: begin
                    if (ready) begin
                        mem_q    <= 1'b0;
                        waited_q <= 1'b0;
                        state_q  <= ST_WR_WAIT;
                    end
                end
                ST_RD_REQ: begin
                    if (ready) begin
                        mem_q    <= 1'b0;
                        waited_q <= 1'b0;
                        state_q  <= ST_RD_WAIT;
                    end
                end
                ST_WR_WAIT: begin
                    if (!waited_q) begin
                        waited_q <= 1'b1;
                    end else if (ready) begin
                        cur_q  <= cur_d;
                        mem_q  <= 1'b1;
                        addr_q <= cur_d;
                        if (lastHit) begin
                            state_q <= ST_RD_REQ;
                            rw_q    <= 1'b1;
                        end else begin
                            state_q <= ST_WR_REQ;
                            rw_q    <= 1'b0;
                            data_q  <= genPattern;
                        end
                    end
                end
                ST_RD_WAIT: begin
                    if (!waited_q) begin
                        waited_q <= 1'b1;
                    end else if (ready) begin
                        err_q <= err_d;
                        if (mismatch && (err_q == '0)) begin
                            firstErr_q <= cur_q;
                        end
                        cur_q <= cur_d;
                        if (!lastHit) begin
                            state_q <= ST_RD_REQ;
                            mem_q   <= 1'b1;
                            rw_q    <= 1'b1;
                            addr_q  <= cur_d;
                        end else begin
`ifdef SRAM_BIST_INV_PASS_EN
                            state_q <= ST_WR2_REQ;
                            mem_q   <= 1'b1;
                            rw_q    <= 1'b0;
                            addr_q  <= cur_d;
                            data_q  <= genPattern;
`else
                            state_q <= ST_DONE;
                            busy_q  <= 1'b0;
                            done_q  <= 1'b1;
                            pass_q  <= (err_d == '0);
`endif
                        end
                    end
                end
`ifdef SRAM_BIST_INV_PASS_EN
                ST_WR2_REQ: begin
                    if (ready) begin
                        mem_q    <= 1'b0;
                        waited_q <= 1'b0;
                        state_q  <= ST_WR2_WAIT;
                    end
                end
                ST_RD2_REQ: begin
                    if (ready) begin
                        mem_q    <= 1'b0;
                        waited_q <= 1'b0;
                        state_q  <= ST_RD2_WAIT;
                    end
                end
                ST_WR2_WAIT: begin
                    if (!waited_q) begin
                        waited_q <= 1'b1;
                    end else if (ready) begin
                        cur_q  <= cur_d;
                        mem_q  <= 1'b1;
                        addr_q <= cur_d;
                        if (lastHit) begin
                            state_q <= ST_RD2_REQ;
                            rw_q    <= 1'b1;
                        end else begin
                            state_q <= ST_WR2_REQ;
                            rw_q    <= 1'b0;
                            data_q  <= genPattern;
                        end
                    end
                end
                ST_RD2_WAIT: begin
                    if (!waited_q) begin
                        waited_q <= 1'b1;
                    end else if (ready) begin
                        err_q <= err_d;
                        if (mismatch && (err_q == '0)) begin
                            firstErr_q <= cur_q;
                        end
                        cur_q <= cur_d;
                        if (!lastHit) begin
                            state_q <= ST_RD2_REQ;
                            mem_q   <= 1'b1;
                            rw_q    <= 1'b1;
                            addr_q  <= cur_d;
                        end else begin
                            state_q <= ST_DONE;
                            busy_q  <= 1'b0;
                            done_q  <= 1'b1;
                            pass_q  <= (err_d == '0);
                        end
                    end
                end
`endif
                default: begin
                    state_q <= ST_IDLE;
                    mem_q   <= 1'b0;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign mem            = mem_q;
    assign rw             = rw_q;
    assign addr           = addr_q;
    assign data_f2s       = data_q;
    assign busy           = busy_q;
    assign done           = done_q;
    assign pass           = pass_q;
    assign err_cnt        = err_q;
    assign first_err_addr = firstErr_q;

endmodule

// File: tb/tb_sram_bist.sv
// tb_sram_bist: drives sram_bist against a behavioural 2-cycle SRAM controller
// and memory model. Expected requests and results are queued by the stimulus
// and checked by an independent monitor. Define SRAM_BIST_INV_PASS_EN to also
// run the inverted-pass case.
module tb_sram_bist;

    localparam int ADDR_W = 19;
    localparam int DATA_W = 9;
    localparam int ERR_W  = 16;

    logic              clk = 1'b0;
    logic              reset_n = 1'b0;
    logic              start;
    logic [ADDR_W-1:0] addr_first;
    logic [ADDR_W-1:0] addr_last;
    logic [DATA_W-1:0] seed;
    logic              mem;
    logic              rw;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data_f2s;
    logic              ready;
    logic [DATA_W-1:0] data_s2f_r;
    logic              busy;
    logic              done;
    logic              pass;
    logic [ERR_W-1:0]  err_cnt;
    logic [ADDR_W-1:0] first_err_addr;

    typedef struct {
        logic              rw;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
    } req_t;

    typedef struct {
        logic              passExp;
        logic [ERR_W-1:0]  err;
        logic [ADDR_W-1:0] firstErr;
    } res_t;

    req_t reqQ[$];
    res_t resQ[$];
    req_t monReq;
    res_t monRes;

    int checks = 0;
    int failures = 0;
    int acceptCnt = 0;
    bit memSeen = 1'b0;
    bit zeroAddrSeen = 1'b0;
    bit resultArmed = 1'b0;
    bit monitorEn = 1'b1;

    logic              faultEn = 1'b0;
    logic [ADDR_W-1:0] faultAddr = '0;
    logic [DATA_W-1:0] sram [logic [ADDR_W-1:0]];
    int                ctrlCnt;
    logic              ctrlRw;
    logic [ADDR_W-1:0] ctrlAddr;
    logic [DATA_W-1:0] ctrlData;

    sram_bist dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .start          (start),
        .addr_first     (addr_first),
        .addr_last      (addr_last),
        .seed           (seed),
        .mem            (mem),
        .rw             (rw),
        .addr           (addr),
        .data_f2s       (data_f2s),
        .ready          (ready),
        .data_s2f_r     (data_s2f_r),
        .busy           (busy),
        .done           (done),
        .pass           (pass),
        .err_cnt        (err_cnt),
        .first_err_addr (first_err_addr)
    );

    // Free-running clock
    always #5 clk = ~clk;

    // Compare one value and keep the counters up to date
    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    // Memory read with an optional stuck-at-0 fault on bit 0 at one address
    function automatic logic [DATA_W-1:0] readModel(input logic [ADDR_W-1:0] a);
        logic [DATA_W-1:0] v;
        v = sram.exists(a) ? sram[a] : '0;
        if (faultEn && (a == faultAddr)) v[0] = 1'b0;
        return v;
    endfunction

    // Controller model: accept on mem&ready, busy two cycles, then ready with registered read data
    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ready      <= 1'b1;
            ctrlCnt    <= 0;
            data_s2f_r <= '0;
        end else if (ctrlCnt == 0) begin
            if (mem && ready) begin
                ready    <= 1'b0;
                ctrlCnt  <= 2;
                ctrlRw   <= rw;
                ctrlAddr <= addr;
                ctrlData <= data_f2s;
            end
        end else begin
            ctrlCnt <= ctrlCnt - 1;
            if (ctrlCnt == 1) begin
                ready <= 1'b1;
                if (!ctrlRw) sram[ctrlAddr] = ctrlData;
                else data_s2f_r <= readModel(ctrlAddr);
            end
        end
    end

    // Monitor: pops expected requests on accepted cycles and expected results when done appears
    always @(negedge clk) begin
        if (reset_n) begin
            if (mem) memSeen = 1'b1;
            if (mem && ready) begin
                acceptCnt++;
                if (addr == '0) zeroAddrSeen = 1'b1;
                if (monitorEn) begin
                    checkOutput("req_pending", 32'(reqQ.size() > 0), 32'd1);
                    if (reqQ.size() > 0) begin
                        monReq = reqQ.pop_front();
                        checkOutput("req_rw", 32'(rw), 32'(monReq.rw));
                        checkOutput("req_addr", 32'(addr), 32'(monReq.addr));
                        if (!monReq.rw) checkOutput("req_wdata", 32'(data_f2s), 32'(monReq.data));
                    end
                end
            end
            if (resultArmed && !start && done) begin
                resultArmed = 1'b0;
                checkOutput("res_pending", 32'(resQ.size() > 0), 32'd1);
                if (resQ.size() > 0) begin
                    monRes = resQ.pop_front();
                    checkOutput("res_pass", 32'(pass), 32'(monRes.passExp));
                    checkOutput("res_err_cnt", 32'(err_cnt), 32'(monRes.err));
                    checkOutput("res_first_err_addr", 32'(first_err_addr), 32'(monRes.firstErr));
                end
            end
        end
    end

    task automatic pushReq(input logic r, input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
        req_t x;
        x.rw = r; x.addr = a; x.data = d;
        reqQ.push_back(x);
    endtask

    task automatic pushResult(input logic p, input logic [ERR_W-1:0] e, input logic [ADDR_W-1:0] f);
        res_t x;
        x.passExp = p; x.err = e; x.firstErr = f;
        resQ.push_back(x);
    endtask

    // Hand-computed traffic for range 0x10..0x13 with seed 0x055
    task automatic pushCase1();
        pushReq(1'b0, 19'h00010, 9'h045);
        pushReq(1'b0, 19'h00011, 9'h044);
        pushReq(1'b0, 19'h00012, 9'h047);
        pushReq(1'b0, 19'h00013, 9'h046);
        pushReq(1'b1, 19'h00010, 9'h000);
        pushReq(1'b1, 19'h00011, 9'h000);
        pushReq(1'b1, 19'h00012, 9'h000);
        pushReq(1'b1, 19'h00013, 9'h000);
    endtask

    // One-cycle start pulse with the range and seed held around it
    task automatic applyStimulus(input logic [ADDR_W-1:0] f, input logic [ADDR_W-1:0] l,
                                 input logic [DATA_W-1:0] s, input bit arm);
        @(posedge clk); #1;
        addr_first = f;
        addr_last  = l;
        seed       = s;
        start      = 1'b1;
        if (arm) resultArmed = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    // Start a test, wait a bounded time for done, then check latency, traffic and leftovers
    task automatic runCase(input string name, input logic [ADDR_W-1:0] f, input logic [ADDR_W-1:0] l,
                           input logic [DATA_W-1:0] s, input int expAccepts, input int limit);
        int cycles;
        acceptCnt = 0;
        applyStimulus(f, l, s, 1'b1);
        cycles = 0;
        while (!done && cycles < limit + 5) begin
            @(negedge clk);
            cycles++;
        end
        checkOutput({name, "_done"}, 32'(done), 32'd1);
        checkOutput({name, "_latency_ok"}, 32'(cycles <= limit), 32'd1);
        repeat (3) @(negedge clk);
        checkOutput({name, "_busy"}, 32'(busy), 32'd0);
        checkOutput({name, "_accepts"}, 32'(acceptCnt), 32'(expAccepts));
        checkOutput({name, "_req_left"}, 32'(reqQ.size()), 32'd0);
        checkOutput({name, "_res_left"}, 32'(resQ.size()), 32'd0);
    endtask

    // Safety net so the run always ends
    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation did not finish, checks=%0d failures=%0d", checks, failures);
        $fatal(1, "[TB] watchdog expired");
    end

    // Directed test sequence
    initial begin
        int cyc;
        start      = 1'b0;
        addr_first = '0;
        addr_last  = '0;
        seed       = '0;
        repeat (3) @(posedge clk);
        #1;
        checkOutput("rst_mem", 32'(mem), 32'd0);
        checkOutput("rst_rw", 32'(rw), 32'd1);
        checkOutput("rst_addr", 32'(addr), 32'd0);
        checkOutput("rst_data_f2s", 32'(data_f2s), 32'd0);
        checkOutput("rst_busy", 32'(busy), 32'd0);
        checkOutput("rst_done", 32'(done), 32'd0);
        checkOutput("rst_pass", 32'(pass), 32'd0);
        checkOutput("rst_err_cnt", 32'(err_cnt), 32'd0);
        checkOutput("rst_first_err_addr", 32'(first_err_addr), 32'd0);
        @(negedge clk);
        reset_n = 1'b1;

        // Good memory, four-word range
        pushCase1();
        pushResult(1'b1, 16'd0, 19'h0);
        runCase("c1", 19'h00010, 19'h00013, 9'h055, 8, 40);

        // Stuck bit 0 at 0x12
        faultEn = 1'b1;
        faultAddr = 19'h00012;
        pushCase1();
        pushResult(1'b0, 16'd1, 19'h00012);
        runCase("c2", 19'h00010, 19'h00013, 9'h055, 8, 40);
        faultEn = 1'b0;

        // Empty range: immediate pass, no traffic
        memSeen = 1'b0;
        pushResult(1'b1, 16'd0, 19'h0);
        runCase("c3", 19'h00005, 19'h00004, 9'h055, 0, 2);
        checkOutput("c3_mem_never", 32'(memSeen), 32'd0);

        // Range at the top of the address space must not wrap to 0
        zeroAddrSeen = 1'b0;
        pushReq(1'b0, 19'h7FFFE, 9'h154);
        pushReq(1'b0, 19'h7FFFF, 9'h155);
        pushReq(1'b1, 19'h7FFFE, 9'h000);
        pushReq(1'b1, 19'h7FFFF, 9'h000);
        pushResult(1'b1, 16'd0, 19'h0);
        runCase("c4", 19'h7FFFE, 19'h7FFFF, 9'h0AA, 4, 30);
        checkOutput("c4_no_addr_zero", 32'(zeroAddrSeen), 32'd0);

        // Reset while a write request is pending, then a clean rerun
        monitorEn = 1'b0;
        acceptCnt = 0;
        applyStimulus(19'h00010, 19'h00013, 9'h055, 1'b0);
        cyc = 0;
        while (!(mem && acceptCnt >= 1) && cyc < 20) begin
            @(negedge clk);
            cyc++;
        end
        checkOutput("c5_mem_before_reset", 32'(mem), 32'd1);
        #1;
        reset_n = 1'b0;
        #1;
        checkOutput("c5_mem_async", 32'(mem), 32'd0);
        checkOutput("c5_busy", 32'(busy), 32'd0);
        checkOutput("c5_done", 32'(done), 32'd0);
        checkOutput("c5_rw", 32'(rw), 32'd1);
        reqQ.delete();
        resQ.delete();
        resultArmed = 1'b0;
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        monitorEn = 1'b1;
        pushCase1();
        pushResult(1'b1, 16'd0, 19'h0);
        runCase("c5", 19'h00010, 19'h00013, 9'h055, 8, 40);

`ifdef SRAM_BIST_INV_PASS_EN
        // Single word, normal then inverted pattern
        pushReq(1'b0, 19'h00020, 9'h020);
        pushReq(1'b1, 19'h00020, 9'h000);
        pushReq(1'b0, 19'h00020, 9'h1DF);
        pushReq(1'b1, 19'h00020, 9'h000);
        pushResult(1'b1, 16'd0, 19'h0);
        runCase("c6", 19'h00020, 19'h00020, 9'h000, 4, 30);
`endif

        repeat (2) @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
